// File: rtl/hwag_if.sv
// Crank-wheel I/O bundle for the angle generator: capture input, synchronized echo,
// status LEDs and the two coil drivers.
interface hwag_if;
    logic cap_in;
    logic cap_out;
    logic led1_out;
    logic led2_out;
    logic coil14_out;
    logic coil23_out;

    modport master (
        output cap_in,
        input  cap_out, led1_out, led2_out, coil14_out, coil23_out
    );

    modport slave (
        input  cap_in,
        output cap_out, led1_out, led2_out, coil14_out, coil23_out
    );
endinterface

// File: rtl/hwag.sv
// Hardware angle generator: locks onto a 60-2 crank wheel, interpolates a 12-bit crank
// angle between teeth and drives two wasted-spark coil dwell windows.
module hwag #(
    parameter int unsigned MIN_CAP  = 128,
    parameter int unsigned MAX_CAP  = 65535,
    parameter int unsigned THNB     = 57,
    parameter int unsigned STWD     = 4,
    parameter int unsigned THVL     = 2,
    parameter int unsigned ATOP     = 3839,
    parameter int unsigned IGN_CHRG = 1024,
    parameter int unsigned IGN_ANG  = 3830
) (
    input  logic  clk,
    input  logic  rst,
    hwag_if.slave bus
);
    localparam int unsigned ASPAN  = ATOP + 1;
    localparam int unsigned W14_LO = (IGN_ANG + ASPAN - (IGN_CHRG % ASPAN)) % ASPAN;
    localparam int unsigned W14_HI = IGN_ANG % ASPAN;
    localparam int unsigned W23_LO = (W14_LO + ASPAN / 2) % ASPAN;
    localparam int unsigned W23_HI = (W14_HI + ASPAN / 2) % ASPAN;
    localparam int unsigned TW     = $clog2(THNB + 1);
    localparam logic [16:0] SAT    = 17'(MAX_CAP + 1);

    typedef enum logic [1:0] {WAIT, SEARCH, SYNC} state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic [16:0]   cnt;
    logic [16:0]   p_cur;
    logic [7:0]    disc;
    logic [TW-1:0] tooth;
    logic [10:0]   sub;
    logic [11:0]   angle;
    logic          led1, led2, coil14, coil23;

    logic          cap_ok, stall, gap, last_tooth, tick, leave_sync;
    logic [19:0]   gap_thr;
    logic [10:0]   step;
    logic [11:0]   limit;

    // Window may wrap through angle 0 when lo > hi.
    function automatic logic in_win(logic [11:0] a, int unsigned lo, int unsigned hi);
        if (lo <= hi)
            return (32'(a) >= lo) && (32'(a) < hi);
        else
            return (32'(a) >= lo) || (32'(a) < hi);
    endfunction

    // p_cur still holds the previous period here, so it plays the role of P_prev.
    always_comb begin
        cap_ok     = s2 && !s3 && (cnt >= 17'(MIN_CAP));
        stall      = (cnt == SAT);
        gap_thr    = 20'(THVL) * 20'(p_cur);
        gap        = 20'(cnt) >= gap_thr;
        last_tooth = (tooth == TW'(THNB));
        step       = (p_cur[16:6] == '0) ? 11'd1 : p_cur[16:6];
        tick       = (state == SYNC) && (sub == step - 11'd1);
        limit      = last_tooth ? 12'(ATOP) : ((12'(tooth) << 6) | 12'd63);
        leave_sync = (state == SYNC) && (stall || (cap_ok && (gap != last_tooth)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            cnt    <= '0;
            p_cur  <= '0;
            state  <= WAIT;
            disc   <= '0;
            tooth  <= '0;
            sub    <= '0;
            angle  <= '0;
            led1   <= 1'b0;
            led2   <= 1'b0;
            coil14 <= 1'b0;
            coil23 <= 1'b0;
        end else begin
            s1 <= bus.cap_in;
            s2 <= s1;
            s3 <= s2;

            if (cap_ok) begin
                cnt   <= 17'd1;
                p_cur <= cnt;
            end else if (!stall) begin
                cnt <= cnt + 17'd1;
            end

            coil14 <= (state == SYNC) && !leave_sync && in_win(angle, W14_LO, W14_HI);
            coil23 <= (state == SYNC) && !leave_sync && in_win(angle, W23_LO, W23_HI);

            if (stall) begin
                state <= WAIT;
                disc  <= '0;
                tooth <= '0;
                sub   <= '0;
                angle <= '0;
                led1  <= 1'b0;
            end else begin
                case (state)
                    WAIT: begin
                        if (cap_ok) begin
                            if (disc == 8'(STWD - 1)) begin
                                disc  <= '0;
                                state <= SEARCH;
                            end else begin
                                disc <= disc + 8'd1;
                            end
                        end
                    end
                    SEARCH: begin
                        if (cap_ok && gap) begin
                            state <= SYNC;
                            tooth <= '0;
                            angle <= '0;
                            sub   <= '0;
                            led1  <= 1'b1;
                            led2  <= ~led2;
                        end
                    end
                    SYNC: begin
                        // A capture always wins over a coincident angle tick.
                        if (cap_ok) begin
                            sub <= '0;
                            if (gap != last_tooth) begin
                                state <= WAIT;
                                tooth <= '0;
                                angle <= '0;
                                led1  <= 1'b0;
                            end else if (last_tooth) begin
                                tooth <= '0;
                                angle <= '0;
                                led2  <= ~led2;
                            end else begin
                                tooth <= tooth + TW'(1);
                                angle <= 12'(tooth + TW'(1)) << 6;
                            end
                        end else if (tick) begin
                            sub <= '0;
                            if (angle < limit)
                                angle <= angle + 12'd1;
                        end else begin
                            sub <= sub + 11'd1;
                        end
                    end
                    default: state <= WAIT;
                endcase
            end
        end
    end

    assign bus.cap_out    = s2;
    assign bus.led1_out   = led1;
    assign bus.led2_out   = led2;
    assign bus.coil14_out = coil14;
    assign bus.coil23_out = coil23;
endmodule

// File: tb/tb_hwag.sv
// Bench for hwag: drives a 60-2 wheel and compares outputs against time-stamped
// expectations queued as each tooth is driven.
module tb_hwag;
    localparam int unsigned MAXC = 9999;   // short stall limit keeps the run compact
    localparam int unsigned TP   = 640;
    localparam int unsigned GP   = 1920;
    localparam int unsigned LAT  = 3;      // cap_in rise to capture processing

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_checks = 0;

    typedef enum int {SIG_CAP, SIG_LED1, SIG_LED2, SIG_COIL14, SIG_COIL23, SIG_ANGLE} sig_t;
    typedef struct {
        int unsigned at;
        sig_t        sig;
        int unsigned val;
    } exp_t;
    exp_t sb[$];

    hwag_if bus_i ();

    hwag #(.MAX_CAP(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, int unsigned got, int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    endtask

    function automatic int unsigned observe(sig_t s);
        case (s)
            SIG_CAP:    return 32'(bus_i.cap_out);
            SIG_LED1:   return 32'(bus_i.led1_out);
            SIG_LED2:   return 32'(bus_i.led2_out);
            SIG_COIL14: return 32'(bus_i.coil14_out);
            SIG_COIL23: return 32'(bus_i.coil23_out);
            default:    return 32'(dut.angle);
        endcase
    endfunction

    task automatic expect_at(int unsigned at, sig_t s, int unsigned v);
        exp_t e;
        e.at  = at;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(int unsigned c);
        wait_cyc(c);
        bus_i.cap_in = 1'b1;
        wait_cyc(c + 20);
        bus_i.cap_in = 1'b0;
    endtask

    task automatic tooth_pulse(int unsigned c, int unsigned t, int unsigned rev, bit locked);
        int unsigned x;
        x = c + LAT;
        if (!locked) begin
            expect_at(x, SIG_LED1, 0);
        end else begin
            expect_at(x, SIG_ANGLE, t * 64);
            expect_at(x, SIG_LED1, 1);
            if (t == 0) begin
                if (rev == 0) expect_at(x - 1, SIG_LED1, 0);
                expect_at(x - 1, SIG_LED2, (rev % 2 == 0) ? 0 : 1);
                expect_at(x, SIG_LED2, (rev % 2 == 0) ? 1 : 0);
            end
            if (t == 10) begin
                expect_at(x + 9, SIG_ANGLE, 640);
                expect_at(x + 10, SIG_ANGLE, 641);
                expect_at(x + 20, SIG_ANGLE, 642);
            end
            if (t == 13) begin
                expect_at(x + 540, SIG_COIL23, 0);
                expect_at(x + 541, SIG_COIL23, 1);
            end
            if (t == 29) begin
                expect_at(x + 540, SIG_COIL23, 1);
                expect_at(x + 541, SIG_COIL23, 0);
            end
            if (t == 43) begin
                expect_at(x + 540, SIG_COIL14, 0);
                expect_at(x + 541, SIG_COIL14, 1);
            end
            if (t == 57) begin
                expect_at(x + 1819, SIG_ANGLE, 3829);
                expect_at(x + 1820, SIG_ANGLE, 3830);
                expect_at(x + 1820, SIG_COIL14, 1);
                expect_at(x + 1821, SIG_COIL14, 0);
                expect_at(x + 1910, SIG_ANGLE, 3839);
                expect_at(x + 1919, SIG_ANGLE, 3839);
            end
        end
        pulse(c);
    endtask

    // Scoreboard drain plus width/period measurements on the live outputs.
    logic        p14 = 1'b0, p23 = 1'b0, pl2 = 1'b0;
    int unsigned r14 = 0, r23 = 0, t_l2 = 0;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i].sig.name(), observe(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
        if (bus_i.coil14_out && !p14) r14 = cyc;
        if (!bus_i.coil14_out && p14 && bus_i.led1_out) check("coil14_width", cyc - r14, 10240);
        if (bus_i.coil23_out && !p23) r23 = cyc;
        if (!bus_i.coil23_out && p23 && bus_i.led1_out) check("coil23_width", cyc - r23, 10240);
        if (bus_i.led2_out != pl2) begin
            if (t_l2 != 0) check("led2_period", cyc - t_l2, 38400);
            t_l2 = cyc;
        end
        p14 = bus_i.coil14_out;
        p23 = bus_i.coil23_out;
        pl2 = bus_i.led2_out;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned c;
        int unsigned x20;
        bus_i.cap_in = 1'b0;
        x20 = 0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 bus_i.cap_in = ~bus_i.cap_in;
            @(negedge clk);
            check("rst_cap_out", 32'(bus_i.cap_out), 0);
            check("rst_led1", 32'(bus_i.led1_out), 0);
            check("rst_led2", 32'(bus_i.led2_out), 0);
            check("rst_coil14", 32'(bus_i.coil14_out), 0);
            check("rst_coil23", 32'(bus_i.coil23_out), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_i.cap_in = 1'b0;
        wait_cyc(cyc + 5);

        // Synchronizer latency; this early edge is also below MIN_CAP.
        c = cyc;
        expect_at(c + 1, SIG_CAP, 0);
        expect_at(c + 2, SIG_CAP, 1);
        expect_at(c + 3, SIG_LED1, 0);
        pulse(c);

        // Teeth 54..57 are the four discarded captures; the following gap locks.
        c = cyc + 300;
        for (int t = 54; t <= 57; t++) begin
            tooth_pulse(c, t, 0, 1'b0);
            c += TP;
        end
        c += GP - TP;

        for (int rev = 0; rev < 2; rev++) begin
            for (int t = 0; t <= 57; t++) begin
                if (rev == 1 && t > 20) break;
                if (rev == 1 && t == 20) begin
                    x20 = c + LAT;
                    expect_at(x20 + MAXC, SIG_LED1, 1);
                    expect_at(x20 + MAXC, SIG_COIL23, 1);
                    expect_at(x20 + MAXC, SIG_ANGLE, 1343);
                    expect_at(x20 + MAXC + 1, SIG_LED1, 0);
                    expect_at(x20 + MAXC + 1, SIG_COIL23, 0);
                    expect_at(x20 + MAXC + 1, SIG_COIL14, 0);
                    expect_at(x20 + MAXC + 1, SIG_ANGLE, 0);
                end
                tooth_pulse(c, 32'(t), 32'(rev), 1'b1);
                if (rev == 1 && t == 5) begin
                    expect_at(c + LAT + 100, SIG_ANGLE, 330);
                    expect_at(c + LAT + 101, SIG_LED1, 1);
                    expect_at(c + LAT + 110, SIG_ANGLE, 331);
                    pulse(c + 100);
                end
                c += (t == 57) ? GP : TP;
            end
        end

        wait_cyc(x20 + MAXC + 20);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
